// File: rtl/pipelined_datapath_if.sv
// Instruction/data memory bus of the five-stage LEGv8 datapath.
// The datapath is the master; the memories are the slave side.
interface pipelined_datapath_if #(
   parameter int N = 64
);
   logic [N-1:0] IM_addr;
   logic [31:0]  IM_readData;
   logic [N-1:0] DM_addr;
   logic [N-1:0] DM_writeData;
   logic [N-1:0] DM_readData;
   logic         DM_writeEnable;
   logic         DM_readEnable;

   modport master (
      output IM_addr, DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
      input  IM_readData, DM_readData
   );

   modport slave (
      input  IM_addr, DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
      output IM_readData, DM_readData
   );
endinterface

// File: rtl/pipelined_datapath.sv
// Five-stage LEGv8 datapath (IF/ID/EX/MEM/WB) with hazard unit and branch flush.
// Optional macro FORWARDING_EN: operand forwarding plus 1-cycle load-use stall; otherwise interlock-only.
module pipelined_datapath #(
   parameter int N     = 64,
   parameter int NREGS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg2loc,
   input  logic        AluSrc,
   input  logic [3:0]  AluControl,
   input  logic        Branch,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic        regWrite,
   input  logic        memtoReg,
   output logic [31:0] instr_ID,
   output logic        stall,
   pipelined_datapath_if.master bus
);

   localparam logic [4:0]  XZR     = 5'(NREGS - 1);
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;

   typedef struct packed {
      logic       alu_src;
      logic [3:0] alu_ctl;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
   } ctl_t;

   // IF and IF/ID
   logic [N-1:0] pc;
   logic [N-1:0] pc_d;
   logic [31:0]  instr_d;
   logic         valid_d;

   // ID
   logic [4:0]   rn_d;
   logic [4:0]   rm_d;
   logic [N-1:0] a_d;
   logic [N-1:0] b_d;
   logic [N-1:0] imm_d;
   ctl_t         ctl_d;
   logic         hazard;

   // ID/EX
   logic [N-1:0] pc_e;
   logic [N-1:0] a_e;
   logic [N-1:0] b_e;
   logic [N-1:0] imm_e;
   logic [4:0]   rd_e;
   ctl_t         ctl_e;
`ifdef FORWARDING_EN
   logic [4:0]   rn_e;
   logic [4:0]   rm_e;
`endif

   // EX
   logic [N-1:0] op_a;
   logic [N-1:0] op_b_reg;
   logic [N-1:0] op_b;
   logic [N-1:0] alu_e;
   logic [N-1:0] pcbr_e;
   logic         zero_e;

   // EX/MEM
   logic [N-1:0] alu_m;
   logic [N-1:0] store_m;
   logic [N-1:0] pcbr_m;
   logic [4:0]   rd_m;
   logic         zero_m;
   logic         branch_m;
   logic         memread_m;
   logic         memwrite_m;
   logic         regwrite_m;
   logic         memtoreg_m;
   logic         take_m;

   // MEM/WB
   logic [N-1:0] alu_w;
   logic [N-1:0] rdata_w;
   logic [N-1:0] wb_data;
   logic [4:0]   rd_w;
   logic         regwrite_w;
   logic         memtoreg_w;

   logic [N-1:0] rf [NREGS];

   assign rn_d    = instr_d[9:5];
   assign rm_d    = reg2loc ? instr_d[4:0] : instr_d[20:16];
   assign wb_data = memtoreg_w ? rdata_w : alu_w;
   assign take_m  = branch_m & zero_m;

   always_comb begin
      ctl_d.alu_src    = AluSrc;
      ctl_d.alu_ctl    = AluControl;
      ctl_d.branch     = Branch;
      ctl_d.mem_read   = memRead;
      ctl_d.mem_write  = memWrite;
      ctl_d.reg_write  = regWrite;
      ctl_d.mem_to_reg = memtoReg;
   end

   // Register read with write-before-read bypass from WB
   always_comb begin
      if (rn_d == XZR)                      a_d = '0;
      else if (regwrite_w && rd_w == rn_d)  a_d = wb_data;
      else                                  a_d = rf[rn_d];
      if (rm_d == XZR)                      b_d = '0;
      else if (regwrite_w && rd_w == rm_d)  b_d = wb_data;
      else                                  b_d = rf[rm_d];
   end

   always_comb begin
      imm_d = '0;
      if (instr_d[31:21] == OP_LDUR || instr_d[31:21] == OP_STUR)
         imm_d = {{(N-9){instr_d[20]}}, instr_d[20:12]};
      else if (instr_d[31:24] == OP_CBZ)
         imm_d = {{(N-19){instr_d[23]}}, instr_d[23:5]};
   end

`ifdef FORWARDING_EN
   assign hazard = valid_d && ctl_e.mem_read && (rd_e != XZR) &&
                   ((rd_e == rn_d) || (rd_e == rm_d));
`else
   // Without forwarding, hold ID until the producer reaches WB (covered by the read bypass)
   assign hazard = valid_d &&
                   ((ctl_e.reg_write && (rd_e != XZR) && ((rd_e == rn_d) || (rd_e == rm_d))) ||
                    (regwrite_m      && (rd_m != XZR) && ((rd_m == rn_d) || (rd_m == rm_d))));
`endif

   assign stall = hazard & ~take_m;

   always_comb begin
      op_a     = a_e;
      op_b_reg = b_e;
`ifdef FORWARDING_EN
      if (regwrite_m && rd_m != XZR && rd_m == rn_e)      op_a = alu_m;
      else if (regwrite_w && rd_w != XZR && rd_w == rn_e) op_a = wb_data;
      if (regwrite_m && rd_m != XZR && rd_m == rm_e)      op_b_reg = alu_m;
      else if (regwrite_w && rd_w != XZR && rd_w == rm_e) op_b_reg = wb_data;
`endif
      op_b = ctl_e.alu_src ? imm_e : op_b_reg;
   end

   always_comb begin
      case (ctl_e.alu_ctl)
         4'b0000: alu_e = op_a & op_b;
         4'b0001: alu_e = op_a | op_b;
         4'b0010: alu_e = op_a + op_b;
         4'b0110: alu_e = op_a - op_b;
         4'b0111: alu_e = op_b;
         default: alu_e = '0;
      endcase
   end

   assign zero_e = (alu_e == '0);
   assign pcbr_e = pc_e + {imm_e[N-3:0], 2'b00};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc         <= '0;
         pc_d       <= '0;
         instr_d    <= '0;
         valid_d    <= 1'b0;
         pc_e       <= '0;
         a_e        <= '0;
         b_e        <= '0;
         imm_e      <= '0;
         rd_e       <= '0;
         ctl_e      <= '0;
`ifdef FORWARDING_EN
         rn_e       <= '0;
         rm_e       <= '0;
`endif
         alu_m      <= '0;
         store_m    <= '0;
         pcbr_m     <= '0;
         rd_m       <= '0;
         zero_m     <= 1'b0;
         branch_m   <= 1'b0;
         memread_m  <= 1'b0;
         memwrite_m <= 1'b0;
         regwrite_m <= 1'b0;
         memtoreg_m <= 1'b0;
         alu_w      <= '0;
         rdata_w    <= '0;
         rd_w       <= '0;
         regwrite_w <= 1'b0;
         memtoreg_w <= 1'b0;
      end else begin
         // A taken branch in MEM wins over any stall and squashes the three younger stages
         if (take_m) begin
            pc      <= pcbr_m;
            pc_d    <= '0;
            instr_d <= '0;
            valid_d <= 1'b0;
         end else if (!stall) begin
            pc      <= pc + N'(4);
            pc_d    <= pc;
            instr_d <= bus.IM_readData;
            valid_d <= 1'b1;
         end

         pc_e  <= pc_d;
         a_e   <= a_d;
         b_e   <= b_d;
         imm_e <= imm_d;
         rd_e  <= instr_d[4:0];
`ifdef FORWARDING_EN
         rn_e  <= rn_d;
         rm_e  <= rm_d;
`endif
         if (take_m || stall || !valid_d) ctl_e <= '0;
         else                             ctl_e <= ctl_d;

         alu_m   <= alu_e;
         store_m <= op_b_reg;
         pcbr_m  <= pcbr_e;
         rd_m    <= rd_e;
         zero_m  <= zero_e;
         if (take_m) begin
            branch_m   <= 1'b0;
            memread_m  <= 1'b0;
            memwrite_m <= 1'b0;
            regwrite_m <= 1'b0;
            memtoreg_m <= 1'b0;
         end else begin
            branch_m   <= ctl_e.branch;
            memread_m  <= ctl_e.mem_read;
            memwrite_m <= ctl_e.mem_write;
            regwrite_m <= ctl_e.reg_write;
            memtoreg_m <= ctl_e.mem_to_reg;
         end

         alu_w      <= alu_m;
         rdata_w    <= bus.DM_readData;
         rd_w       <= rd_m;
         regwrite_w <= regwrite_m;
         memtoreg_w <= memtoreg_m;
      end
   end

   // Xi resets to i; the XZR slot is never read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++)
            rf[i] <= (i == NREGS - 1) ? '0 : N'(i);
      end else if (regwrite_w && rd_w != XZR) begin
         rf[rd_w] <= wb_data;
      end
   end

   assign instr_ID           = instr_d;
   assign bus.IM_addr        = pc;
   assign bus.DM_addr        = alu_m;
   assign bus.DM_writeData   = store_m;
   assign bus.DM_writeEnable = memwrite_m;
   assign bus.DM_readEnable  = memread_m;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench for pipelined_datapath: the bench acts as main decoder, IM and DM,
// and observes register results through stores on the data bus.
module tb_pipelined_datapath;
   localparam int N = 64;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;

`ifdef FORWARDING_EN
   localparam int DEP_STALL = 0;
   localparam int LU_STALL  = 1;
`else
   localparam int DEP_STALL = 2;
   localparam int LU_STALL  = 2;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        reg2loc, AluSrc, Branch, memRead, memWrite, regWrite, memtoReg;
   logic [3:0]  AluControl;
   logic [31:0] instr_ID;
   logic        stall;

   pipelined_datapath_if #(.N(N)) bus_if ();

   pipelined_datapath #(.N(N), .NREGS(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .reg2loc   (reg2loc),
      .AluSrc    (AluSrc),
      .AluControl(AluControl),
      .Branch    (Branch),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .regWrite  (regWrite),
      .memtoReg  (memtoReg),
      .instr_ID  (instr_ID),
      .stall     (stall),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   // main decoder
   always_comb begin
      reg2loc = 0; AluSrc = 0; AluControl = 4'b0000; Branch = 0;
      memRead = 0; memWrite = 0; regWrite = 0; memtoReg = 0;
      if (instr_ID[31:24] == 8'b10110100) begin
         reg2loc = 1; AluControl = 4'b0111; Branch = 1;
      end else begin
         case (instr_ID[31:21])
            OP_ADD:  begin AluControl = 4'b0010; regWrite = 1; end
            OP_SUB:  begin AluControl = 4'b0110; regWrite = 1; end
            OP_AND:  begin AluControl = 4'b0000; regWrite = 1; end
            OP_ORR:  begin AluControl = 4'b0001; regWrite = 1; end
            OP_LDUR: begin AluSrc = 1; AluControl = 4'b0010; memRead = 1; regWrite = 1; memtoReg = 1; end
            OP_STUR: begin reg2loc = 1; AluSrc = 1; AluControl = 4'b0010; memWrite = 1; end
            default: ;
         endcase
      end
   end

   logic [31:0]  imem [64];
   logic [N-1:0] dmem [64];

   assign bus_if.IM_readData = (bus_if.IM_addr < 256) ? imem[bus_if.IM_addr[7:2]] : 32'h0;
   assign bus_if.DM_readData = dmem[bus_if.DM_addr[8:3]];

   always @(posedge clk)
      if (bus_if.DM_writeEnable) dmem[bus_if.DM_addr[8:3]] <= bus_if.DM_writeData;

   // bus monitor, one sample per cycle
   logic [N-1:0] pc_q[$];
   logic [N-1:0] wa_q[$];
   logic [N-1:0] wd_q[$];
   logic [N-1:0] ra_last = '0;
   int  stall_cnt = 0;
   int  rd_cnt = 0;
   bit  mon_en = 0;

   always @(negedge clk) begin
      if (mon_en && reset) begin
         pc_q.push_back(bus_if.IM_addr);
         if (stall) stall_cnt++;
         if (bus_if.DM_writeEnable) begin
            wa_q.push_back(bus_if.DM_addr);
            wd_q.push_back(bus_if.DM_writeData);
         end
         if (bus_if.DM_readEnable) begin
            rd_cnt++;
            ra_last = bus_if.DM_addr;
         end
      end
   end

   int total = 0;
   int bad = 0;
   int pb, wb, sb, rb;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
      return {op, rm, 6'd0, rn, rd};
   endfunction

   function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [4:0] rt, input logic [4:0] rn, input logic [8:0] imm);
      return {op, imm, 2'b00, rn, rt};
   endfunction

   function automatic logic [31:0] enc_cbz(input logic [4:0] rt, input logic [18:0] imm);
      return {8'b10110100, imm, rt};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = 32'h0;
   endtask

   // hold reset, note queue bases, release just after a rising edge so cycle 0 is sampled first
   task automatic start_prog();
      mon_en = 0;
      reset = 0;
      repeat (2) @(negedge clk);
      pb = pc_q.size(); wb = wa_q.size(); sb = stall_cnt; rb = rd_cnt;
      @(posedge clk);
      #1;
      reset = 1;
      mon_en = 1;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      bit seen;

      // NOP stream after reset
      clear_imem();
      start_prog();
      run_cycles(4);
      for (int k = 0; k < 4; k++) check_val("nop_pc", pc_q[pb+k], 64'(4*k));
      check_val("nop_wr", 64'(wa_q.size() - wb), 0);
      check_val("nop_rd", 64'(rd_cnt - rb), 0);
      check_val("nop_stall", 64'(stall_cnt - sb), 0);

      // ADD X1,X2,X3 ; SUB X4,X1,X2 ; STUR X4,[XZR,#0x40]
      clear_imem();
      imem[0] = enc_r(OP_ADD, 5'd1, 5'd2, 5'd3);
      imem[1] = enc_r(OP_SUB, 5'd4, 5'd1, 5'd2);
      imem[4] = enc_d(OP_STUR, 5'd4, 5'd31, 9'h40);
      start_prog();
      run_cycles(16);
      check_val("dep_stall", 64'(stall_cnt - sb), 64'(DEP_STALL));
      check_val("dep_nwr", 64'(wa_q.size() - wb), 1);
      check_val("dep_addr", wa_q[wb], 64'h40);
      check_val("dep_x4", wd_q[wb], 64'd3);

      // STUR X5,[X0,#8] ; LDUR X6,[X0,#8] ; ADD X7,X6,X6 ; STUR X7,[X0,#0x10]
      clear_imem();
      imem[0] = enc_d(OP_STUR, 5'd5, 5'd0, 9'd8);
      imem[1] = enc_d(OP_LDUR, 5'd6, 5'd0, 9'd8);
      imem[2] = enc_r(OP_ADD, 5'd7, 5'd6, 5'd6);
      imem[5] = enc_d(OP_STUR, 5'd7, 5'd0, 9'h10);
      start_prog();
      run_cycles(16);
      check_val("lu_stall", 64'(stall_cnt - sb), 64'(LU_STALL));
      check_val("lu_nwr", 64'(wa_q.size() - wb), 2);
      check_val("st_addr", wa_q[wb], 64'd8);
      check_val("st_data", wd_q[wb], 64'd5);
      check_val("lu_nrd", 64'(rd_cnt - rb), 1);
      check_val("ld_addr", ra_last, 64'd8);
      check_val("x7_addr", wa_q[wb+1], 64'h10);
      check_val("x7_data", wd_q[wb+1], 64'd10);

      // CBZ X31,#4 taken; younger ADD/STUR/STUR squashed
      clear_imem();
      imem[0] = enc_cbz(5'd31, 19'd4);
      imem[1] = enc_r(OP_ADD, 5'd8, 5'd2, 5'd3);
      imem[2] = enc_d(OP_STUR, 5'd2, 5'd31, 9'h20);
      imem[3] = enc_d(OP_STUR, 5'd3, 5'd31, 9'h28);
      imem[4] = enc_d(OP_STUR, 5'd8, 5'd31, 9'h30);
      start_prog();
      run_cycles(10);
      for (int k = 0; k < 6; k++) check_val("br_pc", pc_q[pb+k], 64'(4*k));
      check_val("br_nwr", 64'(wa_q.size() - wb), 1);
      check_val("br_addr", wa_q[wb], 64'h30);
      check_val("br_x8", wd_q[wb], 64'd8);
      check_val("br_stall", 64'(stall_cnt - sb), 0);

      // CBZ X1,#4 not taken; ADD X10 survives
      clear_imem();
      imem[0] = enc_cbz(5'd1, 19'd4);
      imem[1] = enc_r(OP_ADD, 5'd10, 5'd2, 5'd3);
      imem[4] = enc_d(OP_STUR, 5'd10, 5'd31, 9'h50);
      start_prog();
      run_cycles(10);
      for (int k = 0; k < 6; k++) check_val("nt_pc", pc_q[pb+k], 64'(4*k));
      check_val("nt_nwr", 64'(wa_q.size() - wb), 1);
      check_val("nt_addr", wa_q[wb], 64'h50);
      check_val("nt_x10", wd_q[wb], 64'd5);

      // ORR X11,X5,X10 ; AND X12,X7,X13
      clear_imem();
      imem[0] = enc_r(OP_ORR, 5'd11, 5'd5, 5'd10);
      imem[1] = enc_r(OP_AND, 5'd12, 5'd7, 5'd13);
      imem[4] = enc_d(OP_STUR, 5'd11, 5'd31, 9'h70);
      imem[5] = enc_d(OP_STUR, 5'd12, 5'd31, 9'h78);
      start_prog();
      run_cycles(12);
      check_val("logic_nwr", 64'(wa_q.size() - wb), 2);
      check_val("orr_data", wd_q[wb], 64'd15);
      check_val("and_addr", wa_q[wb+1], 64'h78);
      check_val("and_data", wd_q[wb+1], 64'd5);
      check_val("logic_stall", 64'(stall_cnt - sb), 0);

      // reset pulsed during a load-use stall
      clear_imem();
      imem[0] = enc_d(OP_LDUR, 5'd6, 5'd0, 9'd8);
      imem[1] = enc_r(OP_ADD, 5'd7, 5'd6, 5'd6);
      imem[4] = enc_d(OP_STUR, 5'd7, 5'd0, 9'h60);
      start_prog();
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (stall) seen = 1;
      end
      check_val("rst_stall_seen", 64'(seen), 1);
      mon_en = 0;
      reset = 0;
      #1;
      check_val("rst_im_addr", bus_if.IM_addr, 0);
      check_val("rst_instr", 64'(instr_ID), 0);
      check_val("rst_stall", 64'(stall), 0);
      check_val("rst_dm_addr", bus_if.DM_addr, 0);
      check_val("rst_dm_wdata", bus_if.DM_writeData, 0);
      check_val("rst_dm_we", 64'(bus_if.DM_writeEnable), 0);
      check_val("rst_dm_re", 64'(bus_if.DM_readEnable), 0);
      clear_imem();
      start_prog();
      run_cycles(10);
      check_val("rst_pc0", pc_q[pb], 0);
      check_val("rst_pc1", pc_q[pb+1], 64'd4);
      check_val("rst_nwr", 64'(wa_q.size() - wb), 0);
      check_val("rst_nrd", 64'(rd_cnt - rb), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipelined_datapath.md
Name: pipelined_datapath

Overview:
- Parametrised five-stage LEGv8 datapath: IF, ID, EX, MEM, WB. Successor to the single-cycle datapath.
- Adds pipeline registers, a hazard unit (load-use stall, branch flush) and operand forwarding.
- Sits between the external main decoder (driven from the ID-stage instruction), instruction memory and data memory.
- Data width N is generic; PC width equals N.

Parameters:
- N, 64, data, register and PC width in bits (valid 32..64).
- NREGS, 32, register-file depth; index NREGS-1 is XZR.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- reg2loc  in  1  ID-stage control: selects Rm (0) or Rt (1) as second read register.
- AluSrc  in  1  ID-stage control: selects ALU B operand, register (0) or signImm (1).
- AluControl  in  4  ID-stage ALU op: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B.
- Branch  in  1  ID-stage control, CBZ.
- memRead  in  1  ID-stage control.
- memWrite  in  1  ID-stage control.
- regWrite  in  1  ID-stage control.
- memtoReg  in  1  ID-stage control.
- IM_readData  in  32  instruction at IM_addr (combinational memory).
- DM_readData  in  N  data memory read data, valid in the same cycle as DM_addr.
- instr_ID  out  32  IF/ID instruction; feeds the external decoder.
- IM_addr  out  N  current PC.
- DM_addr  out  N  MEM-stage ALU result.
- DM_writeData  out  N  MEM-stage store data.
- DM_writeEnable  out  1  MEM-stage memWrite.
- DM_readEnable  out  1  MEM-stage memRead.
- stall  out  1  high while the hazard unit holds PC and IF/ID.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=0.
  - Every pipeline register is cleared to a bubble (instr=0, all control bits 0).
  - Register file Xi=i for i<NREGS-1; XZR reads 0 and ignores writes.
  - All outputs 0.
  - Reset asserted mid-operation discards all in-flight instructions.
- Bubble: a stage whose control bundle is all zero. It causes no register write, no memory access and no branch.
- IF: IM_addr=PC. PC<=PC+4 each cycle unless stall=1 or a branch is taken.
- ID:
  - Read ports: Rn=instr[9:5]; second port = reg2loc ? instr[4:0] : instr[20:16].
  - Register file writes in WB. A same-cycle WB write to a register being read returns the new value (internal write-before-read bypass).
- signImm:
  - LDUR/STUR (opcode[31:21]=11111000010/11111000000): sext(instr[20:12]).
  - CBZ (opcode[31:24]=10110100): sext(instr[23:5]).
  - Otherwise 0.
  - All extended to N bits.
- EX:
  - ALU on forwarded operands; zero = (result==0).
  - PCBranch = PC_EX + (signImm<<2), modulo 2^N; PC wraps silently.
- MEM:
  - Branch taken when Branch_M & zero_M: PC<=PCBranch_M.
  - Same edge: IF/ID, ID/EX and EX/MEM are flushed to bubbles. Penalty is 3 cycles.
  - A taken branch overrides a concurrent stall.
- WB: write data = memtoReg ? readData_W : aluResult_W. Written when regWrite_W and Rd != XZR.
- Forwarding (per ALU operand A and B-register):
  - EX/MEM Rd match, with regWrite_M and Rd!=XZR, selects aluResult_M.
  - Else a MEM/WB match selects the WB data.
  - Else the register value.
  - EX/MEM has priority. Store data (Rt) is forwarded with the same rule.
- Load-use stall:
  - Condition: memRead_EX and Rd_EX matches either ID source register, with Rd_EX != XZR.
  - Effect: stall=1 for 1 cycle. PC and IF/ID hold; a bubble enters ID/EX.
- Latency: a non-hazard instruction writes the register file 4 cycles after it appears on IM_readData. Sustained throughput is 1 instruction/cycle.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: forwarding and the 1-cycle load-use stall exactly as above.
- Undefined:
  - No forwarding paths.
  - stall=1 while any ID source register (not XZR) matches Rd of an ID/EX or EX/MEM stage with regWrite=1.
  - Dependent ALU pairs cost 2 stall cycles; load-use also costs 2.
  - MEM/WB is covered by the write-before-read bypass.

Test Plan:
- Reset release, then a NOP stream: IM_addr=0,4,8,12 on successive cycles; DM enables 0; stall 0.
- ADD X1,X2,X3 then SUB X4,X1,X2 back-to-back:
  - FORWARDING_EN: X4=3 with no stall.
  - Without the macro: stall=1 for 2 cycles, X4=3.
- STUR X5,[X0,#8] then LDUR X6,[X0,#8] then ADD X7,X6,X6:
  - Store cycle: DM_addr=8, DM_writeData=5, DM_writeEnable=1.
  - With memory returning 5: stall=1 for 1 cycle (FORWARDING_EN); X7=10.
- CBZ X31,#4 at PC=0: taken in MEM; next IM_addr=16; the three younger instructions produce no register or memory writes.
- CBZ X1,#4 with X1=1: not taken; PC sequence continues 4,8,12,16 with no flush.
- reset pulsed low mid-stream during a load-use stall: outputs 0 immediately; PC restarts at 0; no stale write occurs after release.
